// File: rtl/out_port_arbiter_pkg.sv
// Shared router_3 state defines: crossbar port encodings, arbiter state
// encodings and small index/encoding helpers used by the output-port arbiters.
package out_port_arbiter_pkg;

  // Crossbar select encodings
  localparam logic [2:0] N_PORT  = 3'd0;
  localparam logic [2:0] E_PORT  = 3'd1;
  localparam logic [2:0] W_PORT  = 3'd2;
  localparam logic [2:0] S_PORT  = 3'd3;
  localparam logic [2:0] L_PORT  = 3'd4;
  localparam logic [2:0] NO_PORT = 3'd7;

  // Arbiter FSM states
  localparam logic ARB_IDLE   = 1'b0;
  localparam logic ARB_LOCKED = 1'b1;

  // Input indices as seen by this arbiter (bit positions of req/tail/rd)
  localparam logic [1:0] IDX_N = 2'd0;
  localparam logic [1:0] IDX_W = 2'd1;
  localparam logic [1:0] IDX_L = 2'd2;

  // Map an input index to the crossbar select code; anything else is invalid
  function automatic logic [2:0] idx_to_port(input logic [1:0] idx);
    logic [2:0] port;
    case (idx)
      IDX_N:   port = N_PORT;
      IDX_W:   port = W_PORT;
      IDX_L:   port = L_PORT;
      default: port = NO_PORT;
    endcase
    return port;
  endfunction

  // One-hot pop vector for an input index; an invalid index pops nothing
  function automatic logic [2:0] idx_onehot(input logic [1:0] idx);
    logic [2:0] vec;
    case (idx)
      IDX_N:   vec = 3'b001;
      IDX_W:   vec = 3'b010;
      IDX_L:   vec = 3'b100;
      default: vec = 3'b000;
    endcase
    return vec;
  endfunction

endpackage

// File: rtl/out_port_arbiter_rr_pick3.sv
// rr_pick3: combinational 3-way round-robin picker. The search starts at
// the input after 'last' (mod 3), so the previous winner has lowest priority.
module rr_pick3
  import out_port_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [1:0] win,
  output logic       any
);

  // Rotating priority scan starting just after the last winner
  always_comb begin
    win = IDX_N;
    any = |req;
    case (last)
      IDX_N: begin
        if (req[1])      win = IDX_W;
        else if (req[2]) win = IDX_L;
        else if (req[0]) win = IDX_N;
        else             win = IDX_N;
      end
      IDX_W: begin
        if (req[2])      win = IDX_L;
        else if (req[0]) win = IDX_N;
        else if (req[1]) win = IDX_W;
        else             win = IDX_N;
      end
      default: begin
        // last == L (and the unused code 3) restart the scan at N
        if (req[0])      win = IDX_N;
        else if (req[1]) win = IDX_W;
        else if (req[2]) win = IDX_L;
        else             win = IDX_N;
      end
    endcase
  end

endmodule

// File: rtl/out_port_arbiter.sv
// out_port_arbiter: per-output-port wormhole arbiter for router_3.
// Picks among the N, W and L input-buffer heads round-robin, holds the grant
// from head flit to tail flit, drives the crossbar select and pops the owner.
// Optional build macro ARB_PKT_TIMEOUT_EN adds a stall timeout that force-
// releases a stuck lock and raises a sticky timeout_err output.
module out_port_arbiter
  import out_port_arbiter_pkg::*;
#(
  parameter int SEL_W = 3
`ifdef ARB_PKT_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_CNT_W       = 7
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             N_req,
  input  logic             W_req,
  input  logic             L_req,
  input  logic             N_tail,
  input  logic             W_tail,
  input  logic             L_tail,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel_out,
  output logic             N_rd,
  output logic             W_rd,
  output logic             L_rd,
  output logic             busy
`ifdef ARB_PKT_TIMEOUT_EN
  ,
  output logic             timeout_err
`endif
);

  logic       state;
  logic [1:0] owner;
  logic [1:0] last;

  logic       state_nxt;
  logic [1:0] owner_nxt;
  logic [1:0] last_nxt;

  logic [2:0] req_vec;
  logic [2:0] tail_vec;
  logic [2:0] rd_vec;
  logic [1:0] win;
  logic       any_req;
  logic       owner_req;
  logic       owner_tail;
  logic       xfer;
  logic       stall_expire;

  assign req_vec  = {L_req, W_req, N_req};
  assign tail_vec = {L_tail, W_tail, N_tail};

  rr_pick3 u_pick (
    .req  (req_vec),
    .last (last),
    .win  (win),
    .any  (any_req)
  );

  // Select the owner's request and tail bits (tails of non-owners are ignored)
  always_comb begin
    owner_req  = 1'b0;
    owner_tail = 1'b0;
    case (owner)
      IDX_N: begin
        owner_req  = req_vec[0];
        owner_tail = tail_vec[0];
      end
      IDX_W: begin
        owner_req  = req_vec[1];
        owner_tail = tail_vec[1];
      end
      IDX_L: begin
        owner_req  = req_vec[2];
        owner_tail = tail_vec[2];
      end
      default: begin
        owner_req  = 1'b0;
        owner_tail = 1'b0;
      end
    endcase
  end

  // A flit moves only when locked, the owner has data and downstream has room
  assign xfer = (state == ARB_LOCKED) && owner_req && out_ready;

`ifdef ARB_PKT_TIMEOUT_EN
  logic [TO_CNT_W-1:0] stall_cnt;

  // The lock is dropped on the stalled cycle that would bring the count
  // up to TIMEOUT_CYCLES
  assign stall_expire = (state == ARB_LOCKED) && !xfer &&
                        (stall_cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1));

  // Stall counter: counts locked cycles without progress, cleared otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt   <= {TO_CNT_W{1'b0}};
      timeout_err <= 1'b0;
    end else begin
      if ((state == ARB_LOCKED) && !xfer && !stall_expire) begin
        stall_cnt <= stall_cnt + TO_CNT_W'(1);
      end else begin
        stall_cnt <= {TO_CNT_W{1'b0}};
      end
      timeout_err <= timeout_err | stall_expire;
    end
  end
`else
  assign stall_expire = 1'b0;
`endif

  // Crossbar select and FIFO pops: only on a real transfer, never a bubble
  always_comb begin
    sel_out = SEL_W'(NO_PORT);
    rd_vec  = 3'b000;
    if (xfer) begin
      sel_out = SEL_W'(idx_to_port(owner));
      rd_vec  = idx_onehot(owner);
    end else begin
      sel_out = SEL_W'(NO_PORT);
      rd_vec  = 3'b000;
    end
  end

  assign N_rd = rd_vec[0];
  assign W_rd = rd_vec[1];
  assign L_rd = rd_vec[2];
  assign busy = (state == ARB_LOCKED);

  // Next-state logic: arbitrate in IDLE, hold the lock until the tail moves
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    case (state)
      ARB_IDLE: begin
        if (any_req) begin
          state_nxt = ARB_LOCKED;
          owner_nxt = win;
          last_nxt  = win;
        end else begin
          state_nxt = ARB_IDLE;
        end
      end
      ARB_LOCKED: begin
        if (xfer && owner_tail) begin
          state_nxt = ARB_IDLE;
        end else if (stall_expire) begin
          state_nxt = ARB_IDLE;
        end else begin
          state_nxt = ARB_LOCKED;
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
      end
    endcase
  end

  // State registers; reset leaves L as last winner so N is served first
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      owner <= IDX_N;
      last  <= IDX_L;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
    end
  end

endmodule

// File: tb/tb_out_port_arbiter.sv
// Self-checking bench for out_port_arbiter. Input FIFOs are modelled as
// queues of tail bits; each expected pop (crossbar select code) is queued as
// stimulus is issued, and a monitor compares it whenever the DUT pops.
module tb_out_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       N_req, W_req, L_req;
  logic       N_tail, W_tail, L_tail;
  logic       out_ready;
  logic [2:0] sel_out;
  logic       N_rd, W_rd, L_rd;
  logic       busy;
`ifdef ARB_PKT_TIMEOUT_EN
  logic       timeout_err;
`endif

  int checks   = 0;
  int failures = 0;

  bit         fq_n[$];
  bit         fq_w[$];
  bit         fq_l[$];
  logic [2:0] exp_q[$];

  logic [2:0] mon_rd;
  logic [2:0] mon_exp;

  always #5 clk = ~clk;

  out_port_arbiter #(
    .SEL_W(3)
`ifdef ARB_PKT_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8), .TO_CNT_W(7)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .N_req(N_req), .W_req(W_req), .L_req(L_req),
    .N_tail(N_tail), .W_tail(W_tail), .L_tail(L_tail),
    .out_ready(out_ready), .sel_out(sel_out),
    .N_rd(N_rd), .W_rd(W_rd), .L_rd(L_rd), .busy(busy)
`ifdef ARB_PKT_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] port_onehot(input logic [2:0] code);
    case (code)
      3'd0:    return 3'b001;
      3'd2:    return 3'b010;
      3'd4:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic drive_inputs();
    N_req  = (fq_n.size() != 0);
    W_req  = (fq_w.size() != 0);
    L_req  = (fq_l.size() != 0);
    N_tail = (fq_n.size() != 0) ? fq_n[0] : 1'b0;
    W_tail = (fq_w.size() != 0) ? fq_w[0] : 1'b0;
    L_tail = (fq_l.size() != 0) ? fq_l[0] : 1'b0;
  endtask

  // Append a packet of nflits to one input FIFO (0=N, 1=W, 2=L)
  task automatic load(input int port, input int nflits, input bit with_tail);
    for (int i = 0; i < nflits; i++) begin
      bit t;
      t = with_tail && (i == nflits - 1);
      if (port == 0)      fq_n.push_back(t);
      else if (port == 1) fq_w.push_back(t);
      else                fq_l.push_back(t);
    end
    drive_inputs();
    #1;
  endtask

  // One clock: the model FIFOs pop whatever the DUT popped at the edge
  task automatic cyc();
    logic [2:0] snap;
    snap = {L_rd, W_rd, N_rd};
    @(posedge clk);
    #1;
    if (snap[0] && fq_n.size() != 0) void'(fq_n.pop_front());
    if (snap[1] && fq_w.size() != 0) void'(fq_w.pop_front());
    if (snap[2] && fq_l.size() != 0) void'(fq_l.pop_front());
    drive_inputs();
    #1;
  endtask

  task automatic clear_fifos();
    fq_n.delete();
    fq_w.delete();
    fq_l.delete();
    drive_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_fifos();
    cyc();
    cyc();
    rst = 1'b0;
    #1;
  endtask

  // Monitor: every pop must match the next queued select; no pop means NO_PORT
  always @(negedge clk) begin
    mon_rd = {L_rd, W_rd, N_rd};
    if (mon_rd != 3'b000) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop: rd=%b sel=%0d with no pop expected at %0t",
                 mon_rd, sel_out, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pop_sel", int'(sel_out), int'(mon_exp));
        check("pop_rd", int'(mon_rd), int'(port_onehot(mon_exp)));
      end
    end else begin
      check("idle_sel", int'(sel_out), 7);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    drive_inputs();

    // 1: reset values, then a 4-flit N packet
    do_reset();
    check("rst_sel", int'(sel_out), 7);
    check("rst_busy", int'(busy), 0);
    check("rst_rd", int'({L_rd, W_rd, N_rd}), 0);
`ifdef ARB_PKT_TIMEOUT_EN
    check("rst_timeout_err", int'(timeout_err), 0);
`endif
    load(0, 4, 1'b1);
    repeat (4) exp_q.push_back(3'd0);
    check("t1_arb_sel", int'(sel_out), 7);
    check("t1_arb_busy", int'(busy), 0);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      if (i == 1) check("t1_first_pop", int'(N_rd), 1);
      check("t1_busy", int'(busy), (i < 5) ? 1 : 0);
    end

    // 2: all three inputs with back-to-back single-flit packets
    do_reset();
    for (int k = 0; k < 2; k++) begin
      load(0, 1, 1'b1);
      load(1, 1, 1'b1);
      load(2, 1, 1'b1);
    end
    exp_q.push_back(3'd0); exp_q.push_back(3'd2); exp_q.push_back(3'd4);
    exp_q.push_back(3'd0); exp_q.push_back(3'd2); exp_q.push_back(3'd4);
    repeat (12) cyc();
    check("t2_grants_done", exp_q.size(), 0);
    check("t2_fifos_empty", fq_n.size() + fq_w.size() + fq_l.size(), 0);
    check("t2_busy", int'(busy), 0);

    // 3: W 3-flit packet stalls by out_ready; L must wait for the tail
    load(1, 3, 1'b1);
    load(2, 1, 1'b1);
    exp_q.push_back(3'd2); exp_q.push_back(3'd2); exp_q.push_back(3'd2);
    exp_q.push_back(3'd4);
    cyc();
    cyc();
    for (int i = 0; i < 5; i++) begin
      out_ready = 1'b0;
      #1;
      check("t3_stall_sel", int'(sel_out), 7);
      check("t3_stall_wrd", int'(W_rd), 0);
      check("t3_stall_busy", int'(busy), 1);
      cyc();
    end
    out_ready = 1'b1;
    #1;
    cyc();
    cyc();
    check("t3_gap_busy", int'(busy), 0);
    cyc();
    cyc();
    check("t3_done", exp_q.size(), 0);

    // 4: single-flit L packet locks for exactly one cycle
    load(2, 1, 1'b1);
    exp_q.push_back(3'd4);
    check("t4_arb_busy", int'(busy), 0);
    cyc();
    check("t4_sel", int'(sel_out), 4);
    check("t4_lrd", int'(L_rd), 1);
    check("t4_busy", int'(busy), 1);
    cyc();
    check("t4_after_busy", int'(busy), 0);
    check("t4_after_lrd", int'(L_rd), 0);

    // 5: reset during the 2nd flit of an N packet
    load(0, 4, 1'b1);
    exp_q.push_back(3'd0); exp_q.push_back(3'd0);
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    cyc();
    clear_fifos();
    rst = 1'b0;
    #1;
    check("t5_sel", int'(sel_out), 7);
    check("t5_busy", int'(busy), 0);
    // last was N before reset; N must still win over W, proving last=L
    load(1, 1, 1'b1);
    load(0, 1, 1'b1);
    exp_q.push_back(3'd0); exp_q.push_back(3'd2);
    cyc();
    check("t5_first_n", int'(N_rd), 1);
    repeat (3) cyc();
    check("t5_done", exp_q.size(), 0);

`ifdef ARB_PKT_TIMEOUT_EN
    // 6: owner underflows mid-packet; lock released after 8 stalled cycles
    do_reset();
    load(0, 2, 1'b0);
    exp_q.push_back(3'd0); exp_q.push_back(3'd0);
    cyc();
    cyc();
    cyc();
    for (int i = 1; i <= 8; i++) begin
      check("t6_stall_busy", int'(busy), 1);
      check("t6_stall_err", int'(timeout_err), 0);
      cyc();
    end
    check("t6_release_busy", int'(busy), 0);
    check("t6_err_set", int'(timeout_err), 1);
    repeat (3) cyc();
    check("t6_err_sticky", int'(timeout_err), 1);
    do_reset();
    check("t6_err_cleared", int'(timeout_err), 0);
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
